line_drawer: RTL and testbench

//   Parametrised line rasteriser. On start it latches an origin, a length and a direction

---
 rtl/line_pkg.sv | 18 +
 rtl/line_step_counter.sv | 36 +++
 rtl/line_drawer.sv | 143 ++++++++++++++
 tb/tb_line_drawer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared types for the line rasteriser: drawing direction and controller state.
package line_pkg;

   typedef enum logic [1:0] {
      VERT  = 2'd0,
      HORIZ = 2'd1,
      DIAG  = 2'd2,
      ADIAG = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAW   = 2'd1,
      FINISH = 2'd2,
      ERR    = 'x
   } state_t;

endpackage

// File: rtl/line_step_counter.sv
// Pixel index counter for the line rasteriser; flags the final index of the line.
module line_step_counter #(
   parameter int unsigned LEN_W = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic [LEN_W-1:0] len,
   output logic [LEN_W-1:0] step,
   output logic             last
);

   logic [LEN_W-1:0] step_q, step_d;

   always_comb begin
      step_d = step_q;
      if (clear) begin
         step_d = '0;
      end else if (inc) begin
         step_d = step_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q <= '0;
      end else begin
         step_q <= step_d;
      end
   end

   assign step = step_q;
   assign last = (step_q == len);

endmodule

// File: rtl/line_drawer.sv
// Line rasteriser: latches origin/length/direction on start and streams clipped pixel
// coordinates over a valid/ready port, one pixel index per retired step.
module line_drawer
   import line_pkg::*;
#(
   parameter int unsigned X_W      = 9,
   parameter int unsigned Y_W      = 8,
   parameter int unsigned LEN_W    = 9,
   parameter int unsigned SCREEN_W = 320,
   parameter int unsigned SCREEN_H = 240
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [X_W-1:0]   x_in,
   input  logic [Y_W-1:0]   y_in,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [X_W-1:0]   pix_x,
   output logic [Y_W-1:0]   pix_y,
   output logic             busy,
   output logic             done
);

   // Wide enough that origin + index never wraps; y has an extra sign bit for ADIAG.
   localparam int unsigned PX_W = ((X_W > LEN_W) ? X_W : LEN_W) + 1;
   localparam int unsigned PY_W = ((Y_W > LEN_W) ? Y_W : LEN_W) + 2;

   state_t             state_q, state_d;
   logic [X_W-1:0]     x0_q, x0_d;
   logic [Y_W-1:0]     y0_q, y0_d;
   logic [LEN_W-1:0]   len_q, len_d;
   dir_t               mode_q, mode_d;

   logic [LEN_W-1:0]   step;
   logic               last;
   logic               cnt_clear;
   logic               cnt_inc;
   logic               retire;

   logic [PX_W-1:0]        px;
   logic signed [PY_W-1:0] py;
   logic signed [PY_W-1:0] y_ext;
   logic signed [PY_W-1:0] i_ext;
   logic                   in_bounds;

   line_step_counter #(
      .LEN_W (LEN_W)
   ) u_step (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .len   (len_q),
      .step  (step),
      .last  (last)
   );

   always_comb begin
      y_ext = $signed(PY_W'(y0_q));
      i_ext = $signed(PY_W'(step));
      px    = PX_W'(x0_q);
      py    = y_ext;
      if (mode_q != VERT) begin
         px = PX_W'(x0_q) + PX_W'(step);
      end
      if (mode_q == VERT || mode_q == DIAG) begin
         py = y_ext + i_ext;
      end else if (mode_q == ADIAG) begin
         py = y_ext - i_ext;
      end
      in_bounds = (px < PX_W'(SCREEN_W)) && !py[PY_W-1] &&
                  (py < $signed(PY_W'(SCREEN_H)));
      pix_valid = (state_q == DRAW) && in_bounds;
      pix_x     = pix_valid ? px[X_W-1:0] : '0;
      pix_y     = pix_valid ? py[Y_W-1:0] : '0;
   end

   assign busy   = (state_q == DRAW);
   // Clipped pixels retire on their own, one per cycle.
   assign retire = (state_q == DRAW) && ((pix_valid && pix_ready) || !in_bounds);

   always_comb begin
      state_d   = state_q;
      x0_d      = x0_q;
      y0_d      = y0_q;
      len_d     = len_q;
      mode_d    = mode_q;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = DRAW;
               x0_d      = x_in;
               y0_d      = y_in;
               len_d     = len;
               mode_d    = dir_t'(mode);
               cnt_clear = 1'b1;
            end
         end
         DRAW: begin
            if (abort) begin
               state_d = IDLE;
            end else if (retire) begin
               if (last) begin
                  done    = 1'b1;
                  state_d = FINISH;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         FINISH: begin
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: state_d = ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         len_q   <= '0;
         mode_q  <= VERT;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         len_q   <= len_d;
         mode_q  <= mode_d;
      end
   end

endmodule

// File: tb/tb_line_drawer.sv
// Bench for line_drawer: per-cycle comparison against a behavioural line model, directed
// scenarios pinned with literal pixel lists, then randomized traffic.
module tb_line_drawer;

   localparam int MD_VERT  = 0;
   localparam int MD_HORIZ = 1;
   localparam int MD_DIAG  = 2;
   localparam int MD_ADIAG = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [8:0] x_in = '0;
   logic [7:0] y_in = '0;
   logic [8:0] len = '0;
   logic       abort = 1'b0;
   logic       pix_ready = 1'b1;
   logic       pix_valid;
   logic [8:0] pix_x;
   logic [7:0] pix_y;
   logic       busy;
   logic       done;

   line_drawer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .x_in      (x_in),
      .y_in      (y_in),
      .len       (len),
      .abort     (abort),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model state: 0 = idle, 1 = drawing, 2 = waiting for start to drop.
   int m_state = 0, m_i = 0, m_x = 0, m_y = 0, m_len = 0, m_mode = 0;
   int cyc = 0, acc_cyc = 0, done_cnt = 0, done_rel = -1, first_rel = -1;
   int log_q[$];
   bit armed = 1'b0;

   always @(negedge clk) begin : cmp
      int px, py, ex, ey;
      bit inb, ret, ev, ed, eb;
      cyc++;
      if (armed) begin
         px  = m_x + ((m_mode != MD_VERT) ? m_i : 0);
         py  = m_y + ((m_mode == MD_VERT || m_mode == MD_DIAG) ? m_i : 0)
                   - ((m_mode == MD_ADIAG) ? m_i : 0);
         inb = (px < 320) && (py >= 0) && (py < 240);
         eb  = (m_state == 1);
         ev  = eb && inb;
         ex  = ev ? px : 0;
         ey  = ev ? py : 0;
         ret = eb && ((inb && pix_ready) || !inb);
         ed  = ret && (m_i == m_len) && !abort;
         chk("pix_valid", int'(pix_valid), int'(ev));
         chk("pix_x", int'(pix_x), ex);
         chk("pix_y", int'(pix_y), ey);
         chk("busy", int'(busy), int'(eb));
         chk("done", int'(done), int'(ed));

         if (pix_valid && pix_ready) begin
            log_q.push_back(int'(pix_x) * 256 + int'(pix_y));
            if (log_q.size() == 1) first_rel = cyc - acc_cyc;
         end
         if (done) begin
            done_cnt++;
            done_rel = cyc - acc_cyc;
         end

         if (reset) begin
            m_state = 0; m_i = 0; m_x = 0; m_y = 0; m_len = 0; m_mode = 0;
         end else begin
            case (m_state)
               0: if (start) begin
                  m_state = 1; m_i = 0; acc_cyc = cyc;
                  m_x = int'(x_in); m_y = int'(y_in); m_len = int'(len); m_mode = int'(mode);
               end
               1: begin
                  if (abort) m_state = 0;
                  else if (ret) begin
                     if (m_i == m_len) m_state = 2;
                     else m_i++;
                  end
               end
               default: if (!start) m_state = 0;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_line(input int md, input int x, input int y, input int l);
      mode  = 2'(md);
      x_in  = 9'(x);
      y_in  = 8'(y);
      len   = 9'(l);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      int n = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && n < bound) begin
         tick();
         n++;
      end
      chk({name, " done seen"}, done_cnt - d0, 1);
   endtask

   function automatic int pk(input int x, input int y);
      return x * 256 + y;
   endfunction

   initial begin
      int d0;
      tick();
      armed = 1'b1;
      tick();
      chk("reset busy", int'(busy), 0);
      chk("reset valid", int'(pix_valid), 0);
      reset = 1'b0;
      tick();

      // VERT from (10,20), 4 pixels
      log_q.delete();
      start_line(MD_VERT, 10, 20, 3);
      wait_done("vert", 20);
      chk("vert count", log_q.size(), 4);
      for (int i = 0; i < 4 && i < log_q.size(); i++) chk("vert pixel", log_q[i], pk(10, 20 + i));
      chk("vert first cycle", first_rel, 1);
      chk("vert done cycle", done_rel, 4);
      tick(); tick();

      // HORIZ at right edge: three clipped steps
      log_q.delete();
      start_line(MD_HORIZ, 318, 5, 4);
      wait_done("horiz", 20);
      chk("horiz count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("horiz p0", log_q[0], pk(318, 5));
         chk("horiz p1", log_q[1], pk(319, 5));
      end
      chk("horiz done cycle", done_rel, 5);
      tick(); tick();

      // ADIAG off the top edge
      log_q.delete();
      start_line(MD_ADIAG, 0, 1, 3);
      wait_done("adiag", 20);
      chk("adiag count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("adiag p0", log_q[0], pk(0, 1));
         chk("adiag p1", log_q[1], pk(1, 0));
      end
      chk("adiag done cycle", done_rel, 4);
      tick(); tick();

      // DIAG with backpressure on cycles 2-4
      log_q.delete();
      d0 = done_cnt;
      start_line(MD_DIAG, 50, 60, 2);
      tick();
      pix_ready = 1'b0;
      tick(); tick(); tick();
      pix_ready = 1'b1;
      wait_done("diag", 20);
      chk("diag count", log_q.size(), 3);
      for (int i = 0; i < 3 && i < log_q.size(); i++) chk("diag pixel", log_q[i], pk(50 + i, 60 + i));
      chk("diag done cycle", done_rel, 6);
      tick(); tick();
      chk("diag done total", done_cnt - d0, 1);

      // start held high through FINISH must not retrigger
      mode = 2'(MD_HORIZ); x_in = 9'd5; y_in = 8'd5; len = 9'd0; start = 1'b1;
      wait_done("hold", 20);
      d0 = done_cnt;
      repeat (10) tick();
      chk("no retrigger", done_cnt - d0, 0);
      chk("hold busy", int'(busy), 0);
      start = 1'b0;
      tick();
      log_q.delete();
      start_line(MD_HORIZ, 7, 9, 0);
      wait_done("retrigger", 20);
      chk("retrigger count", log_q.size(), 1);
      if (log_q.size() == 1) chk("retrigger pixel", log_q[0], pk(7, 9));
      tick(); tick();

      // abort at i=2 of len=7
      log_q.delete();
      d0 = done_cnt;
      start_line(MD_VERT, 100, 100, 7);
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort busy", int'(busy), 0);
      repeat (12) tick();
      chk("abort count", log_q.size(), 3);
      chk("abort no done", done_cnt - d0, 0);

      // reset mid-line
      log_q.delete();
      d0 = done_cnt;
      start_line(MD_VERT, 100, 100, 7);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset busy mid", int'(busy), 0);
      repeat (12) tick();
      chk("reset count", log_q.size(), 3);
      chk("reset no done", done_cnt - d0, 0);

      // randomized traffic
      repeat (3000) begin
         start     = ($urandom_range(0, 99) < 30);
         abort     = ($urandom_range(0, 99) < 3);
         pix_ready = ($urandom_range(0, 99) < 70);
         reset     = ($urandom_range(0, 199) == 0);
         mode      = 2'($urandom_range(0, 3));
         x_in      = 9'($urandom_range(0, 511));
         y_in      = 8'($urandom_range(0, 255));
         len       = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511))
                                                 : 9'($urandom_range(0, 12));
         tick();
      end
      reset = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
